// File: rtl/sha256_pkg.sv
// Shared constants, FSM encoding and word-slice helper for the SHA-256 round controller.
package sha256_pkg;

  localparam int ROUNDS    = 64;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int STATE_W   = NUM_WORDS * WORD_W;
  localparam int RND_W     = $clog2(ROUNDS);

  // Initial hash value H0..H7, packed with H0 in the most significant word.
  localparam logic [STATE_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  // Word idx of a 256-bit packed state; idx 0 is A/H0 at the top, idx 7 is H/H7 at the bottom.
  function automatic logic [WORD_W-1:0] word_get(input logic [STATE_W-1:0] v, input int idx);
    return v[(NUM_WORDS - 1 - idx) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/sha256_hash_add.sv
// Eight independent mod-2^32 adders folding the working state into the chained hash.
module sha256_hash_add
  import sha256_pkg::*;
(
  input  logic [STATE_W-1:0] a_i,
  input  logic [STATE_W-1:0] b_i,
  output logic [STATE_W-1:0] sum_o
);

  // Each word wraps on its own; no carry crosses a word boundary.
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    assign sum_o[(NUM_WORDS - 1 - i) * WORD_W +: WORD_W] = word_get(a_i, i) + word_get(b_i, i);
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Round sequencer for a single-round SHA-256 datapath: owns working state A..H and the
// chained hash, steps the round index for the external K ROM / scheduler, does the final add.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a block; accept loads IV or the chained hash
// ST_ROUND | one round per cycle while wt_v_i is high, stalls otherwise
// ST_FINAL | folds working state into the chained hash
// ST_DONE  | hash_o valid, held until the consumer takes it with yumi_i
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic               first_i,
  output logic               ready_o,
  output logic               sched_start_o,
  output logic [RND_W-1:0]   round_o,
  input  logic               wt_v_i,
  output logic               wt_yumi_o,
  output logic [STATE_W-1:0] state_o,
  input  logic [STATE_W-1:0] state_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [STATE_W-1:0] hash_o
);

  ctrl_state_e        state_q;
  logic [RND_W-1:0]   round_q;
  logic [STATE_W-1:0] work_q;
  logic [STATE_W-1:0] hash_q;
  logic               chain_q;
  logic [STATE_W-1:0] hash_d;
  logic               new_msg;

  sha256_hash_add u_hash_add (
    .a_i   (hash_q),
    .b_i   (work_q),
    .sum_o (hash_d)
  );

  // After reset chain_q is clear, so a block without first_i still starts from the IV.
  assign new_msg = first_i | ~chain_q;

  assign ready_o       = (state_q == ST_IDLE);
  assign sched_start_o = v_i & ready_o;
  assign wt_yumi_o     = wt_v_i & (state_q == ST_ROUND);
  assign v_o           = (state_q == ST_DONE);
  assign round_o       = round_q;
  assign state_o       = work_q;
  assign hash_o        = hash_q;

  // Block sequencing FSM with working state, chained hash and round counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      work_q  <= '0;
      hash_q  <= '0;
      chain_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (v_i) begin
            if (new_msg) begin
              hash_q <= SHA256_IV;
              work_q <= SHA256_IV;
            end else begin
              work_q <= hash_q;
            end
            round_q <= '0;
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (wt_v_i) begin
            work_q <= state_i;
            // The counter parks on the last round rather than wrapping; the next accept clears it.
            if (round_q == RND_W'(ROUNDS - 1)) begin
              state_q <= ST_FINAL;
            end else begin
              round_q <= round_q + RND_W'(1);
            end
          end
        end
        ST_FINAL: begin
          hash_q  <= hash_d;
          chain_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (yumi_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
